// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin owner of one shared 8:1 single-bit mux
module mux8_rr_scheduler #(
   parameter int HOLD_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic [7:0] din,
   output logic [7:0] gnt,
   output logic [2:0] sel,
   output logic       y,
   output logic       valid,
   output logic       busy
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state_q;
   logic [2:0] ptr_q;
   logic [3:0] cnt_q;
   logic [2:0] win;
   logic       rel;
   // first requester at or after ptr; scanning downward lets the nearest one win
   always_comb begin
      win = ptr_q;
      for (int k = 7; k >= 0; k--)
         if (req[ptr_q + 3'(k)]) win = ptr_q + 3'(k);
   end
   assign rel   = !req[sel] || cnt_q == 4'(HOLD_MAX - 1);
   assign valid = busy && req[sel];
   assign y     = valid && din[sel];
   // grant FSM: one idle turnaround cycle between every pair of grants
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt     <= '0;
         sel     <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         busy    <= 1'b0;
      end else if (state_q == IDLE) begin
         if (|req) begin
            state_q <= GRANT;
            gnt     <= 8'b1 << win;
            sel     <= win;
            cnt_q   <= '0;
            busy    <= 1'b1;
         end
      end else if (rel) begin
         state_q <= IDLE;
         gnt     <= '0;
         busy    <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= sel + 3'd1;
      end else begin
         cnt_q <= cnt_q + 4'd1;
      end
   end
endmodule
